// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracker for an in-order pipeline.
// Decode is stalled on read-after-write hazards against outstanding writes and
// when a destination's pending counter is already full. Writeback releases
// pending writes. Optional build macro SCOREBOARD_WB_BYPASS_EN lets a source
// whose last outstanding write retires this very cycle issue without waiting.
module reg_scoreboard #(
    parameter int NREGS   = 32,
    parameter int CNTBITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic       issue_use_rs1,
    input  logic       issue_use_rs2,
    input  logic [4:0] issue_rs1,
    input  logic [4:0] issue_rs2,
    input  logic [4:0] issue_rd,
    input  logic       issue_wr,
    input  logic       flush,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    output logic       stall,
    output logic       issue_accept,
    output logic [5:0] inflight_cnt,
    output logic       err_underflow
);

    localparam logic [CNTBITS-1:0] CNT_MAX = '1;
    localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

    // Register 0 is hardwired zero and therefore has no counter at all.
    logic [CNTBITS-1:0] r_cnt [1:NREGS-1];
    logic [5:0]         r_inflight;
    logic               r_err_underflow;

    logic [CNTBITS-1:0] w_cnt_rs1;
    logic [CNTBITS-1:0] w_cnt_rs2;
    logic [CNTBITS-1:0] w_cnt_rd;
    logic [CNTBITS-1:0] w_cnt_wb;
    logic               w_rs1_busy;
    logic               w_rs2_busy;
    logic               w_raw;
    logic               w_sat;
    logic               w_stall;
    logic               w_accept;
    logic               w_inc;
    logic               w_dec;
    logic               w_underflow;
    logic               w_net_up;
    logic               w_net_down;

    // Counter lookup; register 0 and indices beyond the tracked range read 0.
    function automatic logic [CNTBITS-1:0] cnt_of(input logic [4:0] idx);
        logic [CNTBITS-1:0] val;
        val = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (idx == 5'(i)) val = r_cnt[i];
        end
        return val;
    endfunction

    // Counter values seen by each of the four lookup ports.
    always_comb begin
        w_cnt_rs1 = cnt_of(issue_rs1);
        w_cnt_rs2 = cnt_of(issue_rs2);
        w_cnt_rd  = cnt_of(issue_rd);
        w_cnt_wb  = cnt_of(wb_rd);
    end

    // Hazard detection and the resulting issue handshake.
    always_comb begin
        w_rs1_busy = issue_use_rs1 && (issue_rs1 != 5'd0) && (w_cnt_rs1 != '0);
        w_rs2_busy = issue_use_rs2 && (issue_rs2 != 5'd0) && (w_cnt_rs2 != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        // The final outstanding write to this source retires now, so the
        // value is available on the writeback path this same cycle.
        if (wb_valid && (wb_rd == issue_rs1) && (w_cnt_rs1 == CNT_ONE)) w_rs1_busy = 1'b0;
        if (wb_valid && (wb_rd == issue_rs2) && (w_cnt_rs2 == CNT_ONE)) w_rs2_busy = 1'b0;
`endif
        w_raw    = issue_valid && (w_rs1_busy || w_rs2_busy);
        w_sat    = issue_valid && issue_wr && (issue_rd != 5'd0) && (w_cnt_rd == CNT_MAX);
        w_stall  = w_raw || w_sat || flush;
        w_accept = issue_valid && !w_stall;
    end

    // Which counter events take effect at the next edge.
    always_comb begin
        w_inc       = w_accept && issue_wr && (issue_rd != 5'd0);
        w_dec       = wb_valid && (wb_rd != 5'd0) && (w_cnt_wb != '0);
        w_underflow = wb_valid && (wb_rd != 5'd0) && (w_cnt_wb == '0);
        // Simultaneous counted increment and decrement cancel in the total.
        w_net_up    = w_inc && !w_dec;
        w_net_down  = w_dec && !w_inc;
    end

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_cnt
            logic w_inc_sel;
            logic w_dec_sel;
            assign w_inc_sel = w_inc && (issue_rd == 5'(gi));
            assign w_dec_sel = w_dec && (wb_rd == 5'(gi));

            // Per-register pending count; inc and dec on the same register cancel.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt[gi] <= '0;
                end else if (w_inc_sel && !w_dec_sel) begin
                    r_cnt[gi] <= r_cnt[gi] + CNT_ONE;
                end else if (w_dec_sel && !w_inc_sel) begin
                    r_cnt[gi] <= r_cnt[gi] - CNT_ONE;
                end
            end
        end
    endgenerate

    // Total outstanding writes, clamped so it can never wrap either way.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 6'd0;
        end else if (w_net_up && (r_inflight != 6'h3F)) begin
            r_inflight <= r_inflight + 6'd1;
        end else if (w_net_down && (r_inflight != 6'd0)) begin
            r_inflight <= r_inflight - 6'd1;
        end
    end

    // Sticky flag for a release that had no matching pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_underflow <= 1'b0;
        end else if (w_underflow) begin
            r_err_underflow <= 1'b1;
        end
    end

    assign stall         = w_stall;
    assign issue_accept  = w_accept;
    assign inflight_cnt  = r_inflight;
    assign err_underflow = r_err_underflow;

endmodule
